// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF response sampler.
// Holds the sampler FSM state encoding and the default values for the
// challenge width, vote count and settle time used by the top level.
package puf_pkg;

  localparam int DEF_CHAL_W     = 64;
  localparam int DEF_VOTES      = 7;
  localparam int DEF_SETTLE_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_SAMPLE,
    ST_RELAX,
    ST_DONE
  } puf_state_e;

endpackage

// File: rtl/race_arbiter_ff.sv
// Race arbiter capture flop plus 2-flop synchronizer into the Clk domain.
//   Clk, RstN         : system clock / async active-low reset
//   Launch            : launch edge; while low the capture flop is held clear
//   RaceOut0/RaceOut1 : last-stage outputs of the delay chain
//   ArbBit            : synchronized arbiter decision (1 = RaceOut0 won)
// The capture flop is clocked by RaceOut1: if RaceOut0 is already high at
// that edge, path 0 won the race. Kept out of optimization so the race
// geometry is not disturbed by synthesis.
module race_arbiter_ff (
  input  logic Clk,
  input  logic RstN,
  input  logic Launch,
  input  logic RaceOut0,
  input  logic RaceOut1,
  output logic ArbBit
);

  logic clr_n;
  assign clr_n = RstN & Launch;

  (* DONT_TOUCH = "true" *) logic       cap_q;
  (* DONT_TOUCH = "true" *) logic [1:0] sync_q;

  always_ff @(posedge RaceOut1 or negedge clr_n) begin
    if (!clr_n) cap_q <= 1'b0;
    else        cap_q <= RaceOut0;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) sync_q <= '0;
    else       sync_q <= {sync_q[0], cap_q};
  end

  assign ArbBit = sync_q[1];

endmodule

// File: rtl/arbiter_response_sampler.sv
// Arbiter PUF response sampler: accepts a challenge, fires the delay chain
// VOTES times, majority-votes the arbiter bits and presents the response.
//   Clk, RstN                 : clock / async active-low reset
//   ReqValid/ReqReady         : challenge handshake, ReqChallenge payload
//   Challenge, Launch         : drive into the stage chain
//   RaceOut0/RaceOut1         : last-stage outputs
//   RespValid/RespReady       : response handshake
//   RespBit/RespOnes/RespUnstable : majority bit, count of 1 votes, disagreement
// Build option: define PUF_UNSTABLE_FLAG_EN to enable RespUnstable; otherwise
// it is tied low.
module arbiter_response_sampler
  import puf_pkg::*;
#(
  parameter int CHAL_W     = DEF_CHAL_W,
  parameter int VOTES      = DEF_VOTES,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                       Clk,
  input  logic                       RstN,
  input  logic                       ReqValid,
  output logic                       ReqReady,
  input  logic [CHAL_W-1:0]          ReqChallenge,
  output logic [CHAL_W-1:0]          Challenge,
  output logic                       Launch,
  input  logic                       RaceOut0,
  input  logic                       RaceOut1,
  output logic                       RespValid,
  input  logic                       RespReady,
  output logic                       RespBit,
  output logic [$clog2(VOTES+1)-1:0] RespOnes,
  output logic                       RespUnstable
);

  localparam int CNT_W = $clog2(VOTES+1);
  // Timer must reach SETTLE_CYC+1 (FIRE length minus one).
  localparam int TMR_W = $clog2(SETTLE_CYC+2);

  if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
    $error("VOTES must be odd and at least 1");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be at least 1");
  end

  puf_state_e          state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]    votes_q, votes_d;
  logic [CNT_W-1:0]    ones_q, ones_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic                launch_q;
  logic                arb_bit;
  logic                settle_last;

  race_arbiter_ff u_arb (
    .Clk      (Clk),
    .RstN     (RstN),
    .Launch   (launch_q),
    .RaceOut0 (RaceOut0),
    .RaceOut1 (RaceOut1),
    .ArbBit   (arb_bit)
  );

  assign settle_last = (tmr_q == TMR_W'(SETTLE_CYC-1));

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    votes_d = votes_q;
    ones_d  = ones_q;
    chal_d  = chal_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          state_d = ST_LOAD;
          tmr_d   = '0;
          votes_d = '0;
          ones_d  = '0;
          chal_d  = ReqChallenge;
        end
      end
      ST_LOAD: begin
        if (settle_last) begin
          state_d = ST_FIRE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_FIRE: begin
        // settle time plus two synchronizer stages
        if (tmr_q == TMR_W'(SETTLE_CYC+1)) begin
          state_d = ST_SAMPLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        ones_d  = ones_q + CNT_W'(arb_bit);
        if (votes_q != CNT_W'(VOTES)) votes_d = votes_q + 1'b1;
        state_d = ST_RELAX;
        tmr_d   = '0;
      end
      ST_RELAX: begin
        if (settle_last) begin
          tmr_d   = '0;
          state_d = (votes_q < CNT_W'(VOTES)) ? ST_FIRE : ST_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (RespReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      votes_q  <= '0;
      ones_q   <= '0;
      chal_q   <= '0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      votes_q  <= votes_d;
      ones_q   <= ones_d;
      chal_q   <= chal_d;
      // registered from next state so Launch is a clean flop output
      launch_q <= (state_d == ST_FIRE) || (state_d == ST_SAMPLE);
    end
  end

  assign ReqReady  = (state_q == ST_IDLE);
  assign Challenge = chal_q;
  assign Launch    = launch_q;
  assign RespValid = (state_q == ST_DONE);
  assign RespOnes  = ones_q;
  assign RespBit   = (state_q == ST_DONE) && (ones_q > CNT_W'(VOTES/2));

`ifdef PUF_UNSTABLE_FLAG_EN
  assign RespUnstable = (state_q == ST_DONE) && (ones_q != '0) &&
                        (ones_q != CNT_W'(VOTES));
`else
  assign RespUnstable = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_response_sampler.sv
module tb_arbiter_response_sampler;

  localparam int VA = 7;
  localparam int SA = 4;
  localparam int DONE_A = SA + VA*(2*SA+3);
  localparam int DONE_B = 1 + 1*(2*1+3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        req_valid_a = 0, req_ready_a;
  logic [63:0] req_chal_a = '0, chal_a;
  logic        launch_a, r0a = 0, r1a = 0;
  logic        resp_valid_a, resp_ready_a = 0, resp_bit_a, resp_unst_a;
  logic [2:0]  resp_ones_a;

  // DUT B: single vote, one-cycle settle
  logic        req_valid_b = 0, req_ready_b;
  logic [7:0]  req_chal_b = '0, chal_b;
  logic        launch_b, r0b = 0, r1b = 0;
  logic        resp_valid_b, resp_ready_b = 0, resp_bit_b, resp_unst_b;
  logic [0:0]  resp_ones_b;

  arbiter_response_sampler u_dut_a (
    .Clk(clk), .RstN(rst_n), .ReqValid(req_valid_a), .ReqReady(req_ready_a),
    .ReqChallenge(req_chal_a), .Challenge(chal_a), .Launch(launch_a),
    .RaceOut0(r0a), .RaceOut1(r1a), .RespValid(resp_valid_a),
    .RespReady(resp_ready_a), .RespBit(resp_bit_a), .RespOnes(resp_ones_a),
    .RespUnstable(resp_unst_a)
  );

  arbiter_response_sampler #(.CHAL_W(8), .VOTES(1), .SETTLE_CYC(1)) u_dut_b (
    .Clk(clk), .RstN(rst_n), .ReqValid(req_valid_b), .ReqReady(req_ready_b),
    .ReqChallenge(req_chal_b), .Challenge(chal_b), .Launch(launch_b),
    .RaceOut0(r0b), .RaceOut1(r1b), .RespValid(resp_valid_b),
    .RespReady(resp_ready_b), .RespBit(resp_bit_b), .RespOnes(resp_ones_b),
    .RespUnstable(resp_unst_b)
  );

  // Delay-chain model: each launch, the winning path rises 1 ns before the other.
  logic [6:0] pat_a = '0;
  int         vidx_a = 0;
  always @(launch_a) begin
    if (launch_a !== 1'b1) begin
      r0a = 0; r1a = 0;
    end else begin
      if (pat_a[3'(vidx_a % 7)]) begin #1 r0a = 1; #1 r1a = 1; end
      else                       begin #1 r1a = 1; #1 r0a = 1; end
      vidx_a++;
    end
  end

  always @(launch_b) begin
    if (launch_b !== 1'b1) begin
      r0b = 0; r1b = 0;
    end else begin
      #1 r0b = 1; #1 r1b = 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: Launch is low for the first SETTLE cycles, then each vote is
  // S+3 cycles high (fire + sample) followed by S cycles low.
  function automatic logic exp_launch(int e, int s);
    if (e < s) return 1'b0;
    return ((e - s) % (2*s + 3)) < (s + 3);
  endfunction

  function automatic logic exp_unst(int ones, int votes);
`ifdef PUF_UNSTABLE_FLAG_EN
    return (ones != 0) && (ones != votes);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with DUT A idle.
  task automatic run_txn(input logic [63:0] chal, input logic [6:0] pat, input int hold,
                         input logic eb, input int eo, input string tag);
    int lerr, early, unstable;
    logic sb, su;
    logic [2:0] so;
    check({tag, "_ready"}, req_ready_a, 1);
    pat_a = pat; vidx_a = 0;
    req_valid_a = 1; req_chal_a = chal;
    @(posedge clk); @(negedge clk);
    req_valid_a = 0; req_chal_a = ~chal;
    lerr = 0; early = 0;
    for (int e = 0; e < DONE_A; e++) begin
      if (launch_a !== exp_launch(e, SA)) lerr++;
      if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b0) early++;
      @(negedge clk);
    end
    check({tag, "_launch_pattern_errs"}, lerr, 0);
    check({tag, "_early_valid"}, early, 0);
    check({tag, "_valid_at_done"}, resp_valid_a, 1);
    check({tag, "_launch_done"}, launch_a, 0);
    check({tag, "_challenge"}, chal_a, chal);
    check({tag, "_bit"}, resp_bit_a, eb);
    check({tag, "_ones"}, resp_ones_a, 64'(eo));
    check({tag, "_unstable"}, resp_unst_a, exp_unst(eo, VA));
    sb = resp_bit_a; so = resp_ones_a; su = resp_unst_a;
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      req_valid_a = ((h % 2) == 0);
      req_chal_a = {$urandom, $urandom};
      @(negedge clk);
      if (resp_valid_a !== 1'b1 || resp_bit_a !== sb || resp_ones_a !== so ||
          resp_unst_a !== su || chal_a !== chal || req_ready_a !== 1'b0) unstable++;
    end
    req_valid_a = 0;
    if (hold > 0) check({tag, "_hold_stable_errs"}, unstable, 0);
    resp_ready_a = 1;
    @(negedge clk);
    resp_ready_a = 0;
    check({tag, "_valid_after_ready"}, resp_valid_a, 0);
    check({tag, "_idle_after_ready"}, req_ready_a, 1);
  endtask

  typedef struct {
    logic [63:0] chal;
    logic [6:0]  pat;
    int          hold;
    logic        exp_bit;
    int          exp_ones;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1ms;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // pat bit i = 1 means RaceOut0 leads on vote i
    vecs[0] = '{64'hA5A5_A5A5_A5A5_A5A5, 7'b1111111, 0,  1'b1, 7};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 7'b0101010, 0,  1'b0, 3};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'b0000000, 20, 1'b0, 0};
    vecs[3] = '{64'h0000_0000_0000_0001, 7'b1011011, 2,  1'b1, 5};
    vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, 7'b0001111, 1,  1'b1, 4};

    repeat (2) @(negedge clk);
    check("rst_launch", launch_a, 0);
    check("rst_challenge", chal_a, 0);
    check("rst_valid", resp_valid_a, 0);
    check("rst_bit", resp_bit_a, 0);
    check("rst_ones", resp_ones_a, 0);
    check("rst_unstable", resp_unst_a, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready_after_release", req_ready_a, 1);

    foreach (vecs[i])
      run_txn(vecs[i].chal, vecs[i].pat, vecs[i].hold, vecs[i].exp_bit,
              vecs[i].exp_ones, $sformatf("vec%0d", i));

    for (int r = 0; r < 8; r++) begin
      logic [6:0] p;
      int o;
      p = 7'($urandom_range(0, 127));
      o = $countones(p);
      run_txn({$urandom, $urandom}, p, int'($urandom_range(0, 3)), o > VA/2, o,
              $sformatf("rnd%0d", r));
    end

    // Reset during FIRE aborts the evaluation
    begin
      int vcount;
      pat_a = 7'h7F; vidx_a = 0;
      req_valid_a = 1; req_chal_a = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk); @(negedge clk);
      req_valid_a = 0;
      repeat (SA + 2) @(negedge clk);
      check("midfire_launch_high", launch_a, 1);
      #2 rst_n = 0;
      #1;
      check("midfire_launch_async_low", launch_a, 0);
      check("midfire_challenge_cleared", chal_a, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("midfire_ready_after_release", req_ready_a, 1);
      vcount = 0;
      for (int c = 0; c < 100; c++) begin
        if (resp_valid_a !== 1'b0 || launch_a !== 1'b0) vcount++;
        @(negedge clk);
      end
      check("midfire_no_response", vcount, 0);
    end

    // Minimal configuration: one vote, one-cycle settle
    begin
      logic [5:0] lp;
      int lerr;
      lp = 6'b011110;
      lerr = 0;
      check("b_ready", req_ready_b, 1);
      req_valid_b = 1; req_chal_b = 8'h3C;
      @(posedge clk); @(negedge clk);
      req_valid_b = 0;
      for (int e = 0; e < DONE_B; e++) begin
        if (launch_b !== lp[e] || resp_valid_b !== 1'b0) lerr++;
        @(negedge clk);
      end
      check("b_launch_pattern_errs", lerr, 0);
      check("b_valid_at_6", resp_valid_b, 1);
      check("b_bit", resp_bit_b, 1);
      check("b_ones", resp_ones_b, 1);
      check("b_unstable", resp_unst_b, 0);
      check("b_challenge", chal_b, 8'h3C);
      resp_ready_b = 1;
      @(negedge clk);
      resp_ready_b = 0;
      check("b_idle_after_ready", req_ready_b, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_response_sampler.md
ARBITER_RESPONSE_SAMPLER -- requirements
Module: arbiter_response_sampler

Interface
REQ-001 Parameter CHAL_W, default 64, challenge width; one bit per Challenge1Arbiter stage.
REQ-002 Parameter VOTES, default 7, evaluations per response; odd; elaboration error if even or less than 1.
REQ-003 Parameter SETTLE_CYC, default 4, Clk cycles allowed for the delay chain to settle.
REQ-004 Clk  in  1  the single clock; all state on its rising edge.
REQ-005 RstN  in  1  reset, asynchronous, active-low.
REQ-006 ReqValid  in  1  challenge request valid.
REQ-007 ReqReady  out  1  block ready to accept a challenge.
REQ-008 ReqChallenge  in  CHAL_W  challenge to evaluate.
REQ-009 Challenge  out  CHAL_W  registered challenge driven to the stage chain.
REQ-010 Launch  out  1  launch edge driven into In0/In1 of the first stage.
REQ-011 RaceOut0, RaceOut1  in  1 each  Out0/Out1 of the last stage.
REQ-012 RespValid  out  1  response valid.
REQ-013 RespReady  in  1  response consumer ready.
REQ-014 RespBit  out  1  majority-voted response bit.
REQ-015 RespOnes  out  $clog2(VOTES+1)  number of votes that read 1.
REQ-016 RespUnstable  out  1  votes disagreed (see REQ-030).

Function
REQ-017 FSM states: IDLE, LOAD, FIRE, SAMPLE, RELAX, DONE.
REQ-018 ReqReady shall be 1 only in IDLE; a request is accepted on an edge with ReqValid and ReqReady both 1; Challenge registers ReqChallenge on that edge and holds it until the next acceptance.
REQ-019 LOAD: Launch 0 for SETTLE_CYC cycles, then FIRE.
REQ-020 FIRE: Launch 1 for SETTLE_CYC+2 cycles (settle plus 2-flop synchronizer), then SAMPLE.
REQ-021 SAMPLE: one cycle, Launch 1; synchronized arbiter bit added to ones counter, vote counter incremented; then RELAX.
REQ-022 RELAX: Launch 0 for SETTLE_CYC cycles; then FIRE if votes done < VOTES, else DONE.
REQ-023 Arbiter bit = 1 when RaceOut0 rises before RaceOut1, 0 otherwise; captured on RaceOut1 rising edge; capture cleared while Launch is 0.
REQ-024 DONE entered exactly SETTLE_CYC + VOTES*(2*SETTLE_CYC+3) cycles after the accepting edge (81 at defaults).
REQ-025 DONE: RespValid 1; RespBit = (RespOnes > VOTES/2); RespBit, RespOnes, RespUnstable stable while RespValid=1 and RespReady=0.
REQ-026 DONE to IDLE on edge with RespReady=1; next request acceptable the following cycle at earliest.
REQ-027 ReqValid while not in IDLE is ignored; no challenge change mid-evaluation.
REQ-028 Counters never wrap: vote counter saturates at VOTES, ones counter cleared on acceptance.

Reset
REQ-029 RstN low: FSM to IDLE, Launch 0, Challenge 0, RespValid 0, RespBit 0, RespOnes 0, RespUnstable 0, ReqReady 1 after release; assertion mid-evaluation aborts immediately with no response produced; synchronizer and capture cleared.

Configuration
REQ-030 With PUF_UNSTABLE_FLAG_EN defined, RespUnstable = 1 in DONE when RespOnes is neither 0 nor VOTES; without it RespUnstable is tied 0 and the comparison logic is absent.

Structure
REQ-031 Shared package puf_pkg holds the FSM state enum and default constants for CHAL_W, VOTES, SETTLE_CYC.
REQ-032 One sub-module race_arbiter_ff: the RaceOut1-clocked capture flop plus 2-flop synchronizer into Clk, marked DONT_TOUCH like the stage chain.

Verification
REQ-033 Reset mid-FIRE -> Launch 0 asynchronously, RespValid never asserts, ReqReady 1 after release.
REQ-034 Challenge 0xA5A5_A5A5_A5A5_A5A5, model RaceOut0 leads by 1 ns on all votes -> RespValid at cycle 81, RespBit 1, RespOnes 7, RespUnstable 0.
REQ-035 RaceOut1 leads on 4 of 7 votes -> RespBit 0, RespOnes 3, RespUnstable 1 (with macro), 0 (without).
REQ-036 RespReady held 0 for 20 cycles -> outputs stable, ReqValid pulses ignored, Challenge unchanged; release -> IDLE next cycle.
REQ-037 VOTES=1, SETTLE_CYC=1 -> RespValid 6 cycles after acceptance; Launch pattern 0,1,1,1,1,0.
